// File: rtl/gpio_edge_capture_pkg.sv
// rtl/gpio_edge_capture_pkg.sv - shared constants and edge helper for the GPIO input stage
//
// Purpose: register-file word offsets for the input-conditioning registers,
// the default debounce window, and the per-bit edge qualification function
// shared by the capture top.
// Ports: none (package).

package gpio_edge_capture_pkg;

  // Word offsets in the GPMC register map. These extend the existing
  // direction/output/input registers that sit below them.
  localparam int GPIO_LEVEL   = 24;
  localparam int GPIO_STATUS  = 26;
  localparam int GPIO_RISE_EN = 28;
  localparam int GPIO_FALL_EN = 30;

  // Default number of consecutive stable cycles before a level is accepted.
  localparam int GPIO_DB_CYCLES_DEFAULT = 8;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_evt_t;

  // An edge exists only on the cycle the debounced level flips; its
  // direction comes from the level being replaced.
  function automatic edge_evt_t edge_detect(input logic lvl, input logic s2,
                                            input logic update);
    edge_evt_t evt;
    evt.rise = update & ~lvl & s2;
    evt.fall = update & lvl & ~s2;
    return evt;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - one-bit synchroniser, debounce counter and level register
//
// Purpose: brings one asynchronous pad input into the clk domain and only
// accepts a new level after it has been seen for DB_CYCLES consecutive cycles.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   pin_in  in   raw pad input (asynchronous)
//   sync    out  synchronised pin (second flop)
//   lvl     out  debounced level
//   update  out  high on the cycle lvl is about to take the value of sync

module gpio_debounce
  import gpio_edge_capture_pkg::*;
#(
  parameter int DB_CYCLES = GPIO_DB_CYCLES_DEFAULT,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_in,
  output logic sync,
  output logic lvl,
  output logic update
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only advances while the synchronised pin disagrees with the
  // accepted level and restarts at the terminal value, so it can never wrap.
  always_comb begin
    update = 1'b0;
    lvl_d  = lvl_q;
    cnt_d  = cnt_q;
    if (s2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      update = 1'b1;
      lvl_d  = s2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= pin_in;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign sync = s2_q;
  assign lvl  = lvl_q;

endmodule

// File: rtl/gpio_edge_capture.sv
// rtl/gpio_edge_capture.sv - debounced GPIO inputs with sticky W1C edge status and irq
//
// Purpose: conditions WIDTH pad inputs, qualifies debounced edges with the
// per-bit rise/fall enables and latches them into a sticky status register
// that the host clears by writing ones.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   pin_in     in   raw pad inputs [WIDTH]
//   rise_en    in   rising-edge capture enables [WIDTH]
//   fall_en    in   falling-edge capture enables [WIDTH]
//   clr_we     in   strobe applying clr_data to status
//   clr_data   in   write-1-to-clear mask [WIDTH]
//   level_out  out  debounced pin levels [WIDTH]
//   status     out  sticky edge flags [WIDTH]
//   irq        out  OR of status

module gpio_edge_capture
  import gpio_edge_capture_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DB_CYCLES = GPIO_DB_CYCLES_DEFAULT,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic             clr_we,
  input  logic [WIDTH-1:0] clr_data,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] status,
  output logic             irq
);

  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] lvl_w;
  logic [WIDTH-1:0] upd_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] status_q, status_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .pin_in(pin_in[i]),
      .sync  (sync_w[i]),
      .lvl   (lvl_w[i]),
      .update(upd_w[i])
    );
  end

  always_comb begin
    edge_evt_t evt;
    rise_w = '0;
    fall_w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      evt       = edge_detect(lvl_w[i], sync_w[i], upd_w[i]);
      rise_w[i] = evt.rise;
      fall_w[i] = evt.fall;
    end
  end

  // Clear is applied before the new events are OR-ed in, so an event that
  // coincides with a clear of the same bit survives.
  always_comb begin
    clr_mask = clr_we ? clr_data : '0;
    status_d = (status_q & ~clr_mask) | (rise_w & rise_en) | (fall_w & fall_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign level_out = lvl_w;
  assign status    = status_q;
  assign irq       = |status_q;

endmodule

// File: tb/tb_gpio_edge_capture.sv
// tb/tb_gpio_edge_capture.sv - self-checking bench for gpio_edge_capture

module tb_gpio_edge_capture;

  localparam int W  = 16;
  localparam int DB = 8;
  // First edge after a pin change samples it (E0); the event lands DB+1 edges later.
  localparam int EVT_TICKS = DB + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  pin_in;
  logic [W-1:0]  rise_en;
  logic [W-1:0]  fall_en;
  logic          clr_we;
  logic [W-1:0]  clr_data;
  logic [W-1:0]  level_out;
  logic [W-1:0]  status;
  logic          irq;

  int checks = 0;
  int passed = 0;

  // Reference model: pin history and window rule, not a copy of the RTL.
  logic [W-1:0] pin_hist[$];
  logic [W-1:0] s2_hist[$];
  logic [W-1:0] lvl_m;
  logic [W-1:0] st_m;
  int           last_upd[W];
  int           n_edge;

  always #5 clk = ~clk;

  gpio_edge_capture #(.WIDTH(W), .DB_CYCLES(DB), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .pin_in   (pin_in),
    .rise_en  (rise_en),
    .fall_en  (fall_en),
    .clr_we   (clr_we),
    .clr_data (clr_data),
    .level_out(level_out),
    .status   (status),
    .irq      (irq)
  );

  // Advance model and DUT by one clock using the inputs currently applied.
  // A bit's level flips once its synchronised value has disagreed with the
  // accepted level on each of the last DB edges since its previous flip.
  task automatic tick();
    logic [W-1:0] s2v, upd, rise, fall, clrm, past;
    bit ok;
    if (rst) begin
      pin_hist.delete();
      s2_hist.delete();
      lvl_m  = '0;
      st_m   = '0;
      n_edge = 0;
      for (int i = 0; i < W; i++) last_upd[i] = 0;
    end else begin
      n_edge++;
      s2v = (pin_hist.size() >= 2) ? pin_hist[pin_hist.size()-2] : '0;
      s2_hist.push_back(s2v);
      upd = '0;
      for (int i = 0; i < W; i++) begin
        if (n_edge - last_upd[i] >= DB) begin
          ok = 1'b1;
          for (int j = 0; j < DB; j++) begin
            past = s2_hist[s2_hist.size()-1-j];
            if (past[i] == lvl_m[i]) ok = 1'b0;
          end
          upd[i] = ok;
        end
      end
      rise = upd & s2v & ~lvl_m;
      fall = upd & ~s2v & lvl_m;
      clrm = clr_we ? clr_data : '0;
      st_m = (st_m & ~clrm) | (rise & rise_en) | (fall & fall_en);
      for (int i = 0; i < W; i++) begin
        if (upd[i]) begin
          lvl_m[i]    = s2v[i];
          last_upd[i] = n_edge;
        end
      end
      pin_hist.push_back(pin_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pin_in = '0; rise_en = '1; fall_en = '1; clr_we = 1'b0; clr_data = '0;
    repeat (20) begin
      tick();
      checks++;
      if ({level_out, status, irq} !== 33'h0)
        $display("FAIL reset_state got level=%h status=%h irq=%b want 0/0/0", level_out, status, irq);
      else passed++;
    end
    rst = 1'b0;
  endtask

  task automatic test_rise();
    int found = 0;
    pin_in[3] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if ({level_out, status, irq} !== {lvl_m, st_m, |st_m})
        $display("FAIL rise_model t=%0d got %h/%h/%b want %h/%h/%b", k, level_out, status, irq, lvl_m, st_m, |st_m);
      else passed++;
      if (found == 0 && status[3]) found = k;
    end
    checks++;
    if (found != EVT_TICKS) $display("FAIL rise_latency got %0d want %0d", found, EVT_TICKS);
    else passed++;
    checks++;
    if ({level_out, status, irq} !== {16'h0008, 16'h0008, 1'b1})
      $display("FAIL rise_final got %h/%h/%b want 0008/0008/1", level_out, status, irq);
    else passed++;
  endtask

  task automatic test_glitch();
    bit saw_high = 1'b0;
    rise_en = 16'hFFFE; fall_en = 16'hFFFF;
    pin_in[0] = 1'b1;
    repeat (DB - 1) tick();
    pin_in[0] = 1'b0;
    repeat (20) begin
      tick();
      checks++;
      if (level_out[0] !== 1'b0 || status !== 16'h0008)
        $display("FAIL glitch_short got level0=%b status=%h want 0/0008", level_out[0], status);
      else passed++;
    end
    pin_in[0] = 1'b1;
    repeat (DB) tick();
    pin_in[0] = 1'b0;
    repeat (25) begin
      tick();
      if (level_out[0]) saw_high = 1'b1;
      checks++;
      if ({level_out, status, irq} !== {lvl_m, st_m, |st_m})
        $display("FAIL pulse8_model got %h/%h/%b want %h/%h/%b", level_out, status, irq, lvl_m, st_m, |st_m);
      else passed++;
    end
    checks++;
    if (!saw_high || level_out[0] !== 1'b0 || status !== 16'h0009)
      $display("FAIL pulse8_edges got seen_high=%b level0=%b status=%h want 1/0/0009", saw_high, level_out[0], status);
    else passed++;
  endtask

  task automatic test_clear();
    clr_we = 1'b1; clr_data = 16'h0001;
    tick();
    clr_we = 1'b0;
    checks++;
    if (status !== 16'h0008 || irq !== 1'b1)
      $display("FAIL clear_partial got status=%h irq=%b want 0008/1", status, irq);
    else passed++;
    clr_we = 1'b1; clr_data = 16'h0008;
    tick();
    clr_we = 1'b0;
    checks++;
    if (status !== 16'h0000 || irq !== 1'b0)
      $display("FAIL clear_last got status=%h irq=%b want 0000/0", status, irq);
    else passed++;
  endtask

  task automatic test_set_wins();
    rise_en = '1;
    pin_in[5] = 1'b1;
    repeat (EVT_TICKS - 1) begin
      tick();
      checks++;
      if (status !== 16'h0000)
        $display("FAIL setwins_early got status=%h want 0000", status);
      else passed++;
    end
    clr_we = 1'b1; clr_data = 16'h0020;
    tick();
    clr_we = 1'b0;
    checks++;
    if (status !== 16'h0020 || irq !== 1'b1)
      $display("FAIL set_wins got status=%h irq=%b want 0020/1", status, irq);
    else passed++;
    clr_we = 1'b1; clr_data = 16'h0020;
    tick();
    clr_we = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 11) == 0) pin_in[b] = ~pin_in[b];
      if ($urandom_range(0, 40) == 0) rise_en = W'($urandom);
      if ($urandom_range(0, 40) == 0) fall_en = W'($urandom);
      clr_we   = ($urandom_range(0, 7) == 0);
      clr_data = W'($urandom);
      tick();
      checks++;
      if ({level_out, status, irq} !== {lvl_m, st_m, |st_m})
        $display("FAIL random_model k=%0d got %h/%h/%b want %h/%h/%b", k, level_out, status, irq, lvl_m, st_m, |st_m);
      else passed++;
    end
    clr_we = 1'b0;
  endtask

  task automatic test_reset_restart();
    int found;
    rst = 1'b1; pin_in = '1; rise_en = '1; fall_en = '0; clr_we = 1'b0;
    repeat (3) tick();
    checks++;
    if ({level_out, status, irq} !== 33'h0)
      $display("FAIL rst_hold got %h/%h/%b want 0/0/0", level_out, status, irq);
    else passed++;
    rst = 1'b0;
    found = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (found == 0 && status == 16'hFFFF) found = k;
    end
    checks++;
    if (found != EVT_TICKS) $display("FAIL rst_release_latency got %0d want %0d", found, EVT_TICKS);
    else passed++;

    rst = 1'b1; pin_in = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    pin_in[2] = 1'b1;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({level_out, status} !== 32'h0)
      $display("FAIL rst_mid got level=%h status=%h want 0/0", level_out, status);
    else passed++;
    rst = 1'b0;
    found = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      checks++;
      if ({level_out, status, irq} !== {lvl_m, st_m, |st_m})
        $display("FAIL rst_mid_model got %h/%h/%b want %h/%h/%b", level_out, status, irq, lvl_m, st_m, |st_m);
      else passed++;
      if (found == 0 && status[2]) found = k;
    end
    checks++;
    if (found != EVT_TICKS) $display("FAIL rst_mid_restart got %0d want %0d", found, EVT_TICKS);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_clear();
    test_set_wins();
    test_random();
    test_reset_restart();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
